// File: rtl/reg_file_sb_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_sb_pkg
// Shared constants and types for the MIPS general-purpose register file with
// pending-write scoreboard (reg_file_sb). Imported by the interface, the
// per-register pending counter and the top level.
//
// Contents:
//   REG_NUM / DATA_W / ADDR_W   architectural register count and bus widths
//   PEND_BITS / PEND_MAX        pending-counter width and saturation value
//   data_t / reg_addr_t         data word and register index types
//   ZERO_WORD / ZERO_REG_ADDR   constant-zero data word and index of $0
//   READ_* / WRITE_*            enable encodings used by decode and write-back
//   rd_rsp_t                    one read port's response (data + busy)
// -----------------------------------------------------------------------------
package reg_file_sb_pkg;

  localparam int REG_NUM   = 32;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int PEND_BITS = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam data_t     ZERO_WORD     = '0;
  localparam reg_addr_t ZERO_REG_ADDR = '0;

  localparam logic [PEND_BITS-1:0] PEND_MAX = 2'd3;

  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef struct packed {
    data_t data;
    logic  busy;
  } rd_rsp_t;

endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_if.sv
// -----------------------------------------------------------------------------
// reg_file_sb_if
// Bundles every non-clock signal between the pipeline and the register file.
//
//   read port 1/2 : reg_read_en_N, reg_addr_N  -> reg_data_N, reg_busy_N
//   issue         : issue_en, issue_addr        (decode marks a destination)
//   write-back    : write_en, write_addr, write_data
//   control       : flush                       (drop all in-flight writes)
//   status        : sb_overflow                 (sticky saturation flag)
//
// Modports:
//   slave  - the register file (responder)
//   master - the decode / write-back side (requester)
// -----------------------------------------------------------------------------
interface reg_file_sb_if;
  import reg_file_sb_pkg::*;

  logic      reg_read_en_1;
  reg_addr_t reg_addr_1;
  data_t     reg_data_1;
  logic      reg_busy_1;

  logic      reg_read_en_2;
  reg_addr_t reg_addr_2;
  data_t     reg_data_2;
  logic      reg_busy_2;

  logic      issue_en;
  reg_addr_t issue_addr;

  logic      write_en;
  reg_addr_t write_addr;
  data_t     write_data;

  logic      flush;
  logic      sb_overflow;

  modport slave (
    input  reg_read_en_1, reg_addr_1,
    output reg_data_1, reg_busy_1,
    input  reg_read_en_2, reg_addr_2,
    output reg_data_2, reg_busy_2,
    input  issue_en, issue_addr,
    input  write_en, write_addr, write_data,
    input  flush,
    output sb_overflow
  );

  modport master (
    output reg_read_en_1, reg_addr_1,
    input  reg_data_1, reg_busy_1,
    output reg_read_en_2, reg_addr_2,
    input  reg_data_2, reg_busy_2,
    output issue_en, issue_addr,
    output write_en, write_addr, write_data,
    output flush,
    input  sb_overflow
  );

endinterface : reg_file_sb_if

// File: rtl/reg_file_sb_pend_ctr.sv
// -----------------------------------------------------------------------------
// reg_pend_ctr
// Pending-write counter for one architectural register. Counts writes that
// have been issued by decode but not yet written back.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset (count -> 0)
//   inc    in   an instruction targeting this register issued this cycle
//   dec    in   a write-back to this register completed this cycle
//   flush  in   clear the count, overriding inc/dec
//   count  out  current number of outstanding writes
//   sat    out  an increment was dropped because the count is at maximum
// -----------------------------------------------------------------------------
module reg_pend_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  input  logic              flush,
  output logic [PEND_W-1:0] count,
  output logic              sat
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  logic [PEND_W-1:0] count_d;
  logic [PEND_W-1:0] count_q;

  // NOTE: every signal assigned in always_comb gets a default first so no
  //       path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q != CNT_MAX) count_d = count_q + PEND_W'(1);
    end else if (dec && !inc) begin
      // A write-back with nothing pending only updates data.
      if (count_q != '0) count_d = count_q - PEND_W'(1);
    end
  end

  // Reported regardless of flush: the issue was still dropped.
  assign sat = inc && !dec && (count_q == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  //       its pre-edge inputs, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule : reg_pend_ctr

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// 32 x 32-bit MIPS general-purpose register file ($0 reads as zero) with a
// per-register pending-write scoreboard. Decode marks a destination at issue,
// write-back clears the mark, and the busy flag on each read port lets decode
// stall on RAW hazards.
//
// Ports:
//   clk   in      system clock, all state updates on the rising edge
//   rst   in      asynchronous active-low reset: registers, counters and
//                 sb_overflow cleared
//   bus   slave   reg_file_sb_if: two combinational read ports (data + busy),
//                 issue, write-back, flush and the sticky sb_overflow flag
//
// Configuration:
//   REG_FILE_BYPASS_EN  when defined, a same-cycle write-back to a read
//                       register is forwarded to the read port and retires
//                       one pending write in the busy flag. When undefined,
//                       reads return the stored (pre-write) value.
// -----------------------------------------------------------------------------
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int NUM_REGS = REG_NUM,
  parameter int PEND_W   = PEND_BITS
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  data_t regs_d [NUM_REGS];
  data_t regs_q [NUM_REGS];

  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [NUM_REGS-1:0]             sat;

  logic sb_overflow_d;
  logic sb_overflow_q;

  logic wb_live;
  logic wr_hit_1;
  logic wr_hit_2;

  rd_rsp_t rsp_1;
  rd_rsp_t rsp_2;

  // Write-back targeting a real register ($0 writes are discarded).
  assign wb_live = (bus.write_en == WRITE_ENABLE) && (bus.write_addr != ZERO_REG_ADDR);

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (wb_live) regs_d[bus.write_addr] = bus.write_data;
  end

  // NOTE: the array carries a reset because registers must read as zero right
  //       after reset; entry 0 is never written, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= ZERO_WORD;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard: one counter per register, $0 tied to zero.
  // ---------------------------------------------------------------------------
  assign pend[0] = '0;
  assign sat[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    localparam reg_addr_t IDX = reg_addr_t'(r);

    reg_pend_ctr #(
      .PEND_W (PEND_W)
    ) u_pend_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.issue_en && (bus.issue_addr == IDX)),
      .dec   ((bus.write_en == WRITE_ENABLE) && (bus.write_addr == IDX)),
      .flush (bus.flush),
      .count (pend[r]),
      .sat   (sat[r])
    );
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_comb begin
    sb_overflow_d = sb_overflow_q | (|sat);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_overflow_q <= 1'b0;
    else      sb_overflow_q <= sb_overflow_d;
  end

  // ---------------------------------------------------------------------------
  // Read ports (combinational). Busy reflects the state before this cycle's
  // issue, so an instruction's sources never see its own destination mark.
  // ---------------------------------------------------------------------------
  function automatic rd_rsp_t read_port(
    input logic              en,
    input reg_addr_t         addr,
    input data_t             stored,
    input logic [PEND_W-1:0] cnt,
    input logic              wr_hit,
    input data_t             wr_data
  );
    rd_rsp_t rsp;
    rsp.data = ZERO_WORD;
    rsp.busy = 1'b0;
    if ((en == READ_ENABLE) && (addr != ZERO_REG_ADDR)) begin
      if (wr_hit) begin
        // Forwarded write-back retires one of the outstanding writes.
        rsp.data = wr_data;
        rsp.busy = (cnt > PEND_W'(1));
      end else begin
        rsp.data = stored;
        rsp.busy = (cnt != '0);
      end
    end
    return rsp;
  endfunction

  assign wr_hit_1 = BYPASS && wb_live && (bus.write_addr == bus.reg_addr_1);
  assign wr_hit_2 = BYPASS && wb_live && (bus.write_addr == bus.reg_addr_2);

  always_comb begin
    rsp_1 = read_port(bus.reg_read_en_1, bus.reg_addr_1, regs_q[bus.reg_addr_1],
                      pend[bus.reg_addr_1], wr_hit_1, bus.write_data);
    rsp_2 = read_port(bus.reg_read_en_2, bus.reg_addr_2, regs_q[bus.reg_addr_2],
                      pend[bus.reg_addr_2], wr_hit_2, bus.write_data);
  end

  assign bus.reg_data_1  = rsp_1.data;
  assign bus.reg_busy_1  = rsp_1.busy;
  assign bus.reg_data_2  = rsp_2.data;
  assign bus.reg_busy_2  = rsp_2.busy;
  assign bus.sb_overflow = sb_overflow_q;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed testbench for reg_file_sb. The driver applies one vector per cycle
// just after the rising edge and, for vectors that are checked, pushes the
// hand-computed expected read-port response into a queue. A separate monitor
// pops and compares on the falling edge.
// Expectations that depend on REG_FILE_BYPASS_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    data_t d1;
    logic  b1;
    data_t d2;
    logic  b2;
    logic  ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic sample_req = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  // Monitor: compares whenever the driver flags the current cycle as checked.
  always @(negedge clk) begin
    if (sample_req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underrun: got empty queue expected an entry");
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, ".data_1"}, bus.reg_data_1, mon_e.d1);
        check({mon_e.name, ".busy_1"}, {31'd0, bus.reg_busy_1}, {31'd0, mon_e.b1});
        check({mon_e.name, ".data_2"}, bus.reg_data_2, mon_e.d2);
        check({mon_e.name, ".busy_2"}, {31'd0, bus.reg_busy_2}, {31'd0, mon_e.b2});
        check({mon_e.name, ".ovf"},    {31'd0, bus.sb_overflow}, {31'd0, mon_e.ovf});
      end
    end
  end

  task automatic expect_rd(input string name, input data_t d1, input logic b1,
                           input data_t d2, input logic b2, input logic ovf);
    exp_t e;
    e.name = name;
    e.d1   = d1;
    e.b1   = b1;
    e.d2   = d2;
    e.b2   = b2;
    e.ovf  = ovf;
    exp_q.push_back(e);
    sample_req = 1'b1;
  endtask

  task automatic rd(input logic e1, input reg_addr_t a1, input logic e2, input reg_addr_t a2);
    bus.reg_read_en_1 = e1;
    bus.reg_addr_1    = a1;
    bus.reg_read_en_2 = e2;
    bus.reg_addr_2    = a2;
  endtask

  task automatic issue(input reg_addr_t a);
    bus.issue_en   = 1'b1;
    bus.issue_addr = a;
  endtask

  task automatic wb(input reg_addr_t a, input data_t d);
    bus.write_en   = WRITE_ENABLE;
    bus.write_addr = a;
    bus.write_data = d;
  endtask

  // Advance one cycle; single-cycle controls drop back to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    sample_req     = 1'b0;
    bus.issue_en   = 1'b0;
    bus.write_en   = WRITE_DISABLE;
    bus.flush      = 1'b0;
  endtask

  initial begin
    bus.reg_read_en_1 = READ_DISABLE;
    bus.reg_addr_1    = '0;
    bus.reg_read_en_2 = READ_DISABLE;
    bus.reg_addr_2    = '0;
    bus.issue_en      = 1'b0;
    bus.issue_addr    = '0;
    bus.write_en      = WRITE_DISABLE;
    bus.write_addr    = '0;
    bus.write_data    = '0;
    bus.flush         = 1'b0;

    @(posedge clk);
    #1;

    // Reset, then read $5 on both ports.
    rst = 1'b0;
    rd(1'b1, 5'd5, 1'b1, 5'd5);
    expect_rd("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Plain write then read; write to $0 discarded; disabled port reads zero.
    wb(5'd3, 32'hDEAD_BEEF);
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    wb(5'd0, 32'h0000_1234);
    rd(1'b1, 5'd3, 1'b1, 5'd3);
    expect_rd("wr_rd3", 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    rd(1'b1, 5'd0, 1'b0, 5'd3);
    expect_rd("zero_reg", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    // Scoreboard on $7: two issues, two write-backs.
    issue(5'd7);
    rd(1'b1, 5'd7, 1'b0, 5'd0);
    expect_rd("iss7_same_cycle", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    issue(5'd7);
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    expect_rd("iss7_cnt1", 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    expect_rd("iss7_cnt2", 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    wb(5'd7, 32'h0000_0077);
    rd(1'b1, 5'd7, 1'b1, 5'd5);
    expect_rd("wb7_first", BYP ? 32'h77 : 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    wb(5'd7, 32'h0000_0078);
    rd(1'b1, 5'd7, 1'b0, 5'd0);
    expect_rd("wb7_second", BYP ? 32'h78 : 32'h77, BYP ? 1'b0 : 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    expect_rd("wb7_done", 32'h78, 1'b0, 32'h78, 1'b0, 1'b0);
    tick();

    // Saturation on $9: four issues, the fourth is dropped.
    for (int i = 0; i < 4; i++) begin
      issue(5'd9);
      if (i == 3) begin
        rd(1'b1, 5'd9, 1'b0, 5'd0);
        expect_rd("sat_pre", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      end
      tick();
    end
    rd(1'b1, 5'd9, 1'b1, 5'd9);
    expect_rd("sat_ovf", 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      wb(5'd9, 32'h0000_0099);
      rd(1'b0, 5'd0, 1'b1, 5'd5);
      expect_rd("sat_drain", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
    end
    rd(1'b1, 5'd9, 1'b0, 5'd0);
    expect_rd("sat_empty", 32'h99, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Write-back collision with a same-cycle read of $4 (pend=1).
    issue(5'd4);
    tick();
    wb(5'd4, 32'hA5A5_A5A5);
    rd(1'b1, 5'd4, 1'b1, 5'd4);
    expect_rd("collision", BYP ? 32'hA5A5_A5A5 : 32'h0, BYP ? 1'b0 : 1'b1,
              BYP ? 32'hA5A5_A5A5 : 32'h0, BYP ? 1'b0 : 1'b1, 1'b1);
    tick();
    rd(1'b1, 5'd4, 1'b0, 5'd0);
    expect_rd("collision_after", 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Flush with pend[2]=2, plus same-cycle issue and write-back to $2.
    issue(5'd2);
    tick();
    issue(5'd2);
    tick();
    issue(5'd2);
    bus.flush = 1'b1;
    wb(5'd2, 32'h0000_0022);
    rd(1'b1, 5'd2, 1'b0, 5'd0);
    expect_rd("flush_same", BYP ? 32'h22 : 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    rd(1'b1, 5'd2, 1'b1, 5'd2);
    expect_rd("flush_after", 32'h22, 1'b0, 32'h22, 1'b0, 1'b1);
    tick();

    // Simultaneous issue and write-back to $6 from count 1.
    issue(5'd6);
    tick();
    issue(5'd6);
    wb(5'd6, 32'h0000_0066);
    rd(1'b0, 5'd0, 1'b1, 5'd6);
    expect_rd("simul", 32'h0, 1'b0, BYP ? 32'h66 : 32'h0, BYP ? 1'b0 : 1'b1, 1'b1);
    tick();
    rd(1'b1, 5'd6, 1'b0, 5'd0);
    expect_rd("simul_after", 32'h66, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    wb(5'd6, 32'h0000_0067);
    tick();
    rd(1'b1, 5'd6, 1'b0, 5'd0);
    expect_rd("simul_drain", 32'h67, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Write-back with nothing pending: data only, counter does not wrap.
    wb(5'd3, 32'h0000_0033);
    tick();
    rd(1'b1, 5'd3, 1'b0, 5'd0);
    expect_rd("wb_idle", 32'h33, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Issue and write-back to $0 have no effect.
    issue(5'd0);
    wb(5'd0, 32'h0000_0055);
    tick();
    rd(1'b1, 5'd0, 1'b1, 5'd0);
    expect_rd("reg0_ignored", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    // Mid-operation reset with $5 pending and $3 holding data.
    issue(5'd5);
    wb(5'd3, 32'h0000_0044);
    tick();
    rd(1'b1, 5'd5, 1'b1, 5'd3);
    expect_rd("pre_reset", 32'h0, 1'b1, 32'h44, 1'b0, 1'b1);
    tick();
    rd(1'b1, 5'd5, 1'b1, 5'd3);
    rst = 1'b0;
    expect_rd("mid_reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rd(1'b1, 5'd7, 1'b1, 5'd5);
    expect_rd("post_reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_reg_file_sb

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- General-purpose register file: the responder to the decode stage's two read requests (enable plus address), and the sink of write-back.
- Holds 32 x 32-bit MIPS GPRs, with $0 hard-wired to zero.
- Adds a per-register pending-write scoreboard: decode marks a destination register at issue, and write-back clears the mark.
- Decode uses the busy flags to stall on RAW hazards.

Parameters:
- NUM_REGS, 32, number of architectural registers; register index 0 is the constant-zero register.
- PEND_W, 2, width of each per-register pending counter; maximum in-flight writes per register is 2^PEND_W-1 = 3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- reg_read_en_1  in  1  read port 1 enable (READ_ENABLE/READ_DISABLE encoding).
- reg_addr_1  in  5  read port 1 register index.
- reg_data_1  out  32  read port 1 data.
- reg_busy_1  out  1  read port 1 register has an outstanding write.
- reg_read_en_2  in  1  read port 2 enable.
- reg_addr_2  in  5  read port 2 register index.
- reg_data_2  out  32  read port 2 data.
- reg_busy_2  out  1  read port 2 register has an outstanding write.
- issue_en  in  1  instruction leaving decode will write a register.
- issue_addr  in  5  destination index of the issuing instruction.
- write_en  in  1  write-back valid (WRITE_ENABLE encoding).
- write_addr  in  5  write-back register index.
- write_data  in  32  write-back value.
- flush  in  1  discard all in-flight writes; clears the scoreboard.
- sb_overflow  out  1  sticky flag: an issue was dropped at counter saturation.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = ZERO_WORD, all pending counters = 0, sb_overflow = 0.
  - Combinational outputs follow the cleared state immediately.
- Read ports are purely combinational (zero latency):
  - read_en=0 or addr=0 -> data=ZERO_WORD, busy=0.
  - otherwise data=regs[addr], busy=(pend[addr]!=0), unless the bypass rule below applies.
- Write: on the clock edge, if write_en=1 and write_addr!=0, regs[write_addr] <= write_data. Writes to $0 are ignored.
- Pending counter update per register r != 0 each cycle, with inc=issue_en&(issue_addr==r) and dec=write_en&(write_addr==r):
  - inc & !dec -> +1.
  - dec & !inc -> -1, but not below 0: a write-back with count 0 only updates data.
  - both or neither -> unchanged.
- Saturation: inc & !dec with pend=3 -> counter holds at 3 and sb_overflow <= 1. The flag stays set until reset.
- Index 0: counter is constant 0. Issue or write-back to $0 has no scoreboard effect and no overflow.
- flush=1:
  - every counter <= 0 at the edge, overriding same-cycle issue and write-back on the counters.
  - The register array write still occurs.
  - sb_overflow is unaffected.
- Issue does not affect same-cycle busy outputs. The issuing instruction's own sources are evaluated before its destination is marked.
- Both read ports may address the same register; they return identical data and busy.
- Mid-operation reset clears all counters and registers regardless of in-flight writes.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined (write-through bypass): if write_en=1, write_addr!=0 and write_addr==read addr with read enabled, then:
  - data = write_data.
  - busy = (pend[addr] > 1); this write-back retires one pending write.
- Undefined: data = stored value (pre-write), busy = (pend[addr]!=0). Decode stalls one extra cycle on write-back collision.

Decomposition:
- The shared define headers already hold DATA_BUS, REG_ADDR_BUS, ZERO_WORD, ZERO_REG_ADDR and the READ_/WRITE_ enable encodings.
- Add to the global define header:
  - REG_NUM (32).
  - PEND_BUS (1:0).
  - PEND_MAX (2'd3).
- One natural sub-module: reg_pend_ctr, a single saturating up/down counter with flush, instantiated 31 times via generate.

Test Plan:
- Reset then read: rst low, read en=1 addr=5 on both ports -> data=0x00000000, busy=0, sb_overflow=0.
- Write/read: write_en=1 addr=3 data=0xDEADBEEF; next cycle read addr=3 -> 0xDEADBEEF, busy=0. Write addr=0 data=0x1234 -> read $0 = 0.
- Scoreboard:
  - issue $7 twice on consecutive cycles -> busy_1=1 for addr=7.
  - one write-back -> busy stays 1 (count=1).
  - second write-back -> busy=0.
- Saturation: issue $9 four cycles with no write-back -> count=3, sb_overflow=1. Three write-backs -> busy=0.
- Bypass collision: pend[4]=1, write_en=1 addr=4 data=0xA5A5A5A5, read addr=4 same cycle:
  - with REG_FILE_BYPASS_EN -> data=0xA5A5A5A5, busy=0.
  - without -> old data, busy=1.
- Flush/simultaneous: pend[2]=2, issue $2 with flush=1 -> next cycle busy=0. Issue and write-back $6 same cycle from count 1 -> stays 1.
